// File: rtl/maxqueue_source_if.sv
// Sink/source bus of the sorted priority queue: entries in on the sink side,
// highest-priority head out on the source side, plus count and drop status.
interface maxqueue_source_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned PRIO_WIDTH = 32,
  parameter int unsigned TOT_SIZE   = 4
);
  localparam int unsigned CNT_WIDTH = $clog2(TOT_SIZE + 1);

  logic                  sink_valid;
  logic                  sink_ready;
  logic [DATA_WIDTH-1:0] sink_data;
  logic [PRIO_WIDTH-1:0] sink_prio;
  logic                  source_valid;
  logic                  source_ready;
  logic [DATA_WIDTH-1:0] source_data;
  logic [PRIO_WIDTH-1:0] source_prio;
  logic [CNT_WIDTH-1:0]  count;
  logic                  drop;

  // Producer/consumer side (drives entries in, takes the head).
  modport master (
    output sink_valid, sink_data, sink_prio, source_ready,
    input  sink_ready, source_valid, source_data, source_prio, count, drop
  );

  // Queue side.
  modport slave (
    input  sink_valid, sink_data, sink_prio, source_ready,
    output sink_ready, source_valid, source_data, source_prio, count, drop
  );
endinterface

// File: rtl/maxqueue_source.sv
// Sorted priority queue (register array, slot 0 = head). Insert and pop each
// complete in one cycle; equal priorities keep arrival order.
// Optional feature: define MAXQUEUE_OVERFLOW_EN to always accept entries and
// discard the lowest-priority one on overflow (pulsing drop).
module maxqueue_source #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned PRIO_WIDTH = 32,
  parameter int unsigned TOT_SIZE   = 4
) (
  input logic              sink_clk,
  input logic              reset,
  maxqueue_source_if.slave bus
);
  localparam int unsigned CNT_WIDTH = $clog2(TOT_SIZE + 1);
  localparam int unsigned LAST      = TOT_SIZE - 1;

  logic [DATA_WIDTH-1:0] data_q  [TOT_SIZE];
  logic [PRIO_WIDTH-1:0] prio_q  [TOT_SIZE];
  logic [TOT_SIZE-1:0]   occ_q;
  logic [CNT_WIDTH-1:0]  count_q;

  logic [DATA_WIDTH-1:0] data_sh [TOT_SIZE];
  logic [PRIO_WIDTH-1:0] prio_sh [TOT_SIZE];
  logic [TOT_SIZE-1:0]   occ_sh;
  logic [DATA_WIDTH-1:0] data_n  [TOT_SIZE];
  logic [PRIO_WIDTH-1:0] prio_n  [TOT_SIZE];
  logic [TOT_SIZE-1:0]   occ_n;
  logic [CNT_WIDTH-1:0]  count_n;
  logic [CNT_WIDTH-1:0]  pos;

  logic push;
  logic pop;
  logic full;
  logic ins_en;

  assign full = (count_q == CNT_WIDTH'(TOT_SIZE));
  assign push = bus.sink_valid && bus.sink_ready;
  assign pop  = occ_q[0] && bus.source_ready;

  // Pop shift, insert position search on the shifted array, then insert.
  always_comb begin
    for (int i = 0; i < TOT_SIZE; i++) begin
      data_sh[i] = data_q[i];
      prio_sh[i] = prio_q[i];
    end
    occ_sh = occ_q;
    if (pop) begin
      for (int i = 0; i < int'(LAST); i++) begin
        data_sh[i] = data_q[i+1];
        prio_sh[i] = prio_q[i+1];
        occ_sh[i]  = occ_q[i+1];
      end
      data_sh[LAST] = '0;
      prio_sh[LAST] = '0;
      occ_sh[LAST]  = 1'b0;
    end

    // First slot that is empty or strictly lower priority; TOT_SIZE = none.
    pos = CNT_WIDTH'(TOT_SIZE);
    for (int i = int'(LAST); i >= 0; i--) begin
      if (!occ_sh[i] || (prio_sh[i] < bus.sink_prio)) pos = CNT_WIDTH'(i);
    end

    // A full queue with no free slot below the new priority discards it.
    ins_en = push && (pos != CNT_WIDTH'(TOT_SIZE));

    for (int i = 0; i < TOT_SIZE; i++) begin
      data_n[i] = data_sh[i];
      prio_n[i] = prio_sh[i];
    end
    occ_n = occ_sh;
    if (ins_en) begin
      if (pos == '0) begin
        data_n[0] = bus.sink_data;
        prio_n[0] = bus.sink_prio;
        occ_n[0]  = 1'b1;
      end
      for (int i = 1; i < TOT_SIZE; i++) begin
        if (CNT_WIDTH'(i) == pos) begin
          data_n[i] = bus.sink_data;
          prio_n[i] = bus.sink_prio;
          occ_n[i]  = 1'b1;
        end else if (CNT_WIDTH'(i) > pos) begin
          data_n[i] = data_sh[i-1];
          prio_n[i] = prio_sh[i-1];
          occ_n[i]  = occ_sh[i-1];
        end
      end
    end

    count_n = count_q;
    if (push && !pop && !full) count_n = count_q + CNT_WIDTH'(1);
    else if (pop && !push)     count_n = count_q - CNT_WIDTH'(1);
  end

  // Slot array and occupancy count.
  always_ff @(posedge sink_clk) begin
    if (reset) begin
      for (int i = 0; i < TOT_SIZE; i++) begin
        data_q[i] <= '0;
        prio_q[i] <= '0;
      end
      occ_q   <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < TOT_SIZE; i++) begin
        data_q[i] <= data_n[i];
        prio_q[i] <= prio_n[i];
      end
      occ_q   <= occ_n;
      count_q <= count_n;
    end
  end

`ifdef MAXQUEUE_OVERFLOW_EN
  logic drop_q;

  // One-cycle pulse whenever a push into a full, non-popping queue loses an entry.
  always_ff @(posedge sink_clk) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= push && !pop && full;
  end

  assign bus.sink_ready = 1'b1;
  assign bus.drop       = drop_q;
`else
  logic ready_q;

  // Ready tracks the next count so it depends on stored state only.
  always_ff @(posedge sink_clk) begin
    if (reset) ready_q <= 1'b1;
    else       ready_q <= (count_n < CNT_WIDTH'(TOT_SIZE));
  end

  assign bus.sink_ready = ready_q;
  assign bus.drop       = 1'b0;
`endif

  assign bus.source_valid = occ_q[0];
  assign bus.source_data  = data_q[0];
  assign bus.source_prio  = prio_q[0];
  assign bus.count        = count_q;
endmodule

// File: doc/maxqueue_source.md
# maxqueue_source

Sorted priority queue providing the read side of the priority-sink path: accepts (data, priority) entries on a valid/ready sink port and presents the highest-priority stored entry on a valid/ready source port, removing it on each handshake. It sits between the sink-side producer and downstream consumers that must drain entries in descending priority order. Storage is a fully sorted register array, so insert and pop each complete in one cycle.

## Interface
- DATA_WIDTH, 10, data bits per entry
- PRIO_WIDTH, 32, bits per priority (unsigned)
- TOT_SIZE, 4, maximum stored entries (≥2)
- CNT_WIDTH, $clog2(TOT_SIZE+1), width of count output (derived, do not override)

- sink_clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sink_valid  in  1  input entry valid
- sink_ready  out  1  queue can accept an entry this cycle
- sink_data  in  DATA_WIDTH  input data
- sink_prio  in  PRIO_WIDTH  input priority
- source_valid  out  1  head entry present
- source_ready  in  1  consumer takes head this cycle
- source_data  out  DATA_WIDTH  head data
- source_prio  out  PRIO_WIDTH  head priority
- count  out  CNT_WIDTH  number of stored entries
- drop  out  1  one-cycle pulse: an entry was discarded (overflow mode only; 0 otherwise)

## Operation
- Storage: slots 0..TOT_SIZE-1, each with data, prio, occupied bit; occupied slots contiguous from slot 0, sorted non-increasing prio; slot 0 = head.
- push = sink_valid && sink_ready; pop = source_valid && source_ready.
- Insert position p = index of first slot that is empty or has prio strictly less than sink_prio. Equal priorities keep arrival order (new entry placed after existing equals).
- Push only: slots ≥p shift down one; new entry written at p; count+1.
- Pop only: every slot takes content of slot+1; last slot cleared; count−1.
- Push and pop same cycle: result equals pop applied first, then insert into the shifted array (position computed on shifted contents); count unchanged.
- source_valid = occupied[0]; source_data/source_prio = slot 0 contents, registered (no combinational path from sink to source).
- sink_ready = (count < TOT_SIZE); registered-state only, no dependence on source_ready. A full queue cannot push even when popping.
- source_valid high with source_ready low: head and all slots hold, except that a push with higher prio than head replaces head next cycle (head may change while stalled; consumer must sample on handshake).
- Empty pop impossible (source_valid low). Full push impossible (sink_ready low), unless overflow mode.

## Timing
- Reset values: all slots cleared, count=0, source_valid=0, source_data=0, source_prio=0, sink_ready=1, drop=0; effective the cycle after reset sampled high; reset overrides any push/pop that cycle.
- Push-to-source latency: 1 cycle (entry accepted at edge N visible on source after edge N if it becomes head).
- Pop: next head visible after the same edge.
- count updates at the edge of the push/pop.

## Configuration
- MAXQUEUE_OVERFLOW_EN defined: sink_ready tied 1. Push when full: if sink_prio > prio of slot TOT_SIZE−1, insert normally and discard the last slot's entry; else discard the incoming entry. Either case pulses drop for one cycle; count stays TOT_SIZE. With simultaneous pop while full, no discard and no drop.
- Undefined: backpressure as in Operation; drop tied 0.

## Test plan
- Reset, then push prios 5,9,1,7 (data 0x1..0x4), source_ready=0 -> count=4, sink_ready=0, head prio 9 data 0x2; then drain -> order 9,7,5,1.
- Push prio 3 data 0xA then prio 3 data 0xB, drain -> 0xA before 0xB.
- One entry prio 4 stored; same cycle pop and push prio 2 -> source shows prio 2 next cycle, count=1.
- Full (9,7,5,1), source_ready=0, sink_valid with prio 8 -> not accepted, no change; with MAXQUEUE_OVERFLOW_EN -> contents 9,8,7,5, drop=1 one cycle; push prio 0 -> contents unchanged, drop=1.
- Reset asserted mid-drain with count=3 -> next cycle count=0, source_valid=0, sink_ready=1.
